// File: rtl/dac_sample_driver.sv
// Paced sample FIFO feeding a 4-element thermometer DAC, with optional
// data-weighted-averaging element rotation and sticky underrun/saturation flags.
module dac_sample_driver #(
  parameter int DEPTH    = 4,
  parameter int RATE_DIV = 16,
  parameter int DWA_EN   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [2:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       clear_flags,
  output logic [3:0]                 thermo_out,
  output logic                       update_pulse,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       underrun,
  output logic                       sat_flag
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(RATE_DIV);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   count;
  logic [1:0]      ptr;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [2:0]      mem [DEPTH];
  logic [2:0]      head, k;
  logic [3:0]      mapped;
  logic [1:0]      idx;
  logic            push, pop, tick, empty;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (enable) next_state = RUN;
    else        next_state = IDLE;
  end

  assign empty    = (fifo_level == '0);
  assign in_ready = (fifo_level != LW'(DEPTH));
  assign push     = in_valid && in_ready;
  // A tick is only honoured while staying in RUN, so IDLE always shows 0000.
  assign tick     = (state == RUN) && enable && (count == CW'(RATE_DIV - 1));
  assign pop      = tick && !empty;
  assign head     = mem[rd_ptr];

  always_comb begin
    k      = (head > 3'd4) ? 3'd4 : head;
    mapped = 4'b0000;
    idx    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(k)) begin
        if (DWA_EN != 0) begin
          idx         = ptr + 2'(i);
          mapped[idx] = 1'b1;
        end else begin
          mapped[i] = 1'b1;
        end
      end
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      count        <= '0;
      ptr          <= 2'd0;
      thermo_out   <= 4'b0000;
      update_pulse <= 1'b0;
      underrun     <= 1'b0;
      sat_flag     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_level <= fifo_level + LW'(1);
      else if (pop && !push) fifo_level <= fifo_level - LW'(1);
      update_pulse <= pop;

      if (!enable) begin
        count      <= '0;
        ptr        <= 2'd0;
        thermo_out <= 4'b0000;
      end else if (state == RUN) begin
        count <= tick ? '0 : count + 1'b1;
        if (pop) begin
          thermo_out <= mapped;
          // k=4 truncates to 0 here, leaving the pointer in place.
          if (DWA_EN != 0) ptr <= ptr + k[1:0];
        end
      end else begin
        count <= '0;
      end

      if (tick && empty)  underrun <= 1'b1;
      else if (clear_flags) underrun <= 1'b0;
      if (pop && head > 3'd4) sat_flag <= 1'b1;
      else if (clear_flags)   sat_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dac_sample_driver.sv
// Directed bench for dac_sample_driver: one DWA instance and one fixed-mapping
// instance share the same stimulus.
module tb_dac_sample_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] in_data = 3'd0;
  logic       in_valid = 1'b0;
  logic       clear_flags = 1'b0;

  logic       in_ready, update_pulse, underrun, sat_flag;
  logic [3:0] thermo_out;
  logic [2:0] fifo_level;
  logic       f_in_ready, f_update_pulse, f_underrun, f_sat_flag;
  logic [3:0] f_thermo_out;
  logic [2:0] f_fifo_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dac_sample_driver #(.DEPTH(4), .RATE_DIV(4), .DWA_EN(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .clear_flags(clear_flags),
    .thermo_out(thermo_out), .update_pulse(update_pulse),
    .fifo_level(fifo_level), .underrun(underrun), .sat_flag(sat_flag));

  dac_sample_driver #(.DEPTH(4), .RATE_DIV(4), .DWA_EN(0)) dut_fix (
    .clk(clk), .reset(reset), .enable(enable), .in_data(in_data),
    .in_valid(in_valid), .in_ready(f_in_ready), .clear_flags(clear_flags),
    .thermo_out(f_thermo_out), .update_pulse(f_update_pulse),
    .fifo_level(f_fifo_level), .underrun(f_underrun), .sat_flag(f_sat_flag));

  task step;
    @(posedge clk);
    #1;
  endtask

  task do_reset;
    enable = 1'b0; in_valid = 1'b0; clear_flags = 1'b0;
    reset = 1'b1;
    step; step;
    reset = 1'b0;
  endtask

  task push(input logic [2:0] v);
    in_data = v; in_valid = 1'b1;
    step;
    in_valid = 1'b0;
  endtask

  // Steps until update_pulse (of the selected instance) is seen or the budget expires.
  task wait_pulse(input bit fixed, input int maxc, output int n, output bit seen);
    n = 0; seen = 1'b0;
    while (!seen && n < maxc) begin
      step;
      n++;
      seen = fixed ? f_update_pulse : update_pulse;
    end
  endtask

  task test_reset;
    reset = 1'b1; enable = 1'b1; in_valid = 1'b1; in_data = 3'd2;
    step; step;
    reset = 1'b0; enable = 1'b0; in_valid = 1'b0;
    checks++; if (thermo_out !== 4'b0000) begin errors++; $display("[TB] FAIL reset_thermo: got %b expected 0000", thermo_out); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d expected 0", fifo_level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", in_ready); end
    checks++; if (underrun !== 1'b0 || sat_flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b%b expected 00", underrun, sat_flag); end
    checks++; if (update_pulse !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulse: got %b expected 0", update_pulse); end
  endtask

  task test_dwa;
    logic [3:0] exp_t [3] = '{4'b0001, 4'b0110, 4'b1011};
    int exp_n [3] = '{5, 3, 3};
    int n; bit seen;
    do_reset;
    push(3'd1); push(3'd2); push(3'd3);
    checks++; if (fifo_level !== 3'd3) begin errors++; $display("[TB] FAIL dwa_level: got %0d expected 3", fifo_level); end
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_pulse(1'b0, 12, n, seen);
      checks++; if (!seen || n != exp_n[i]) begin errors++; $display("[TB] FAIL dwa_timing%0d: got %0d cycles (seen=%b) expected %0d", i, n, seen, exp_n[i]); end
      checks++; if (thermo_out !== exp_t[i]) begin errors++; $display("[TB] FAIL dwa_thermo%0d: got %b expected %b", i, thermo_out, exp_t[i]); end
      step;
      checks++; if (update_pulse !== 1'b0) begin errors++; $display("[TB] FAIL dwa_single_pulse%0d: got %b expected 0", i, update_pulse); end
    end
    push(3'd1);
    wait_pulse(1'b0, 12, n, seen);
    checks++; if (!seen || thermo_out !== 4'b0100) begin errors++; $display("[TB] FAIL dwa_ptr_end: got %b (seen=%b) expected 0100", thermo_out, seen); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL dwa_no_underrun: got %b expected 0", underrun); end
    enable = 1'b0;
    step;
    checks++; if (thermo_out !== 4'b0000) begin errors++; $display("[TB] FAIL dwa_idle_thermo: got %b expected 0000", thermo_out); end
  endtask

  task test_full;
    logic [3:0] exp_t [4] = '{4'b0001, 4'b0110, 4'b1011, 4'b1111};
    int pulses;
    do_reset;
    for (int i = 1; i <= 5; i++) begin
      in_data = 3'(i % 5); in_valid = 1'b1;
      step;
      if (i == 4) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready: got %b expected 0", in_ready); end
      end
    end
    in_valid = 1'b0;
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("[TB] FAIL full_level: got %0d expected 4", fifo_level); end
    enable = 1'b1;
    pulses = 0;
    for (int c = 0; c < 21; c++) begin
      step;
      if (update_pulse) begin
        checks++;
        if (pulses > 3 || thermo_out !== exp_t[pulses > 3 ? 3 : pulses]) begin
          errors++; $display("[TB] FAIL full_thermo%0d: got %b expected %b", pulses, thermo_out, exp_t[pulses > 3 ? 3 : pulses]);
        end
        pulses++;
      end
    end
    checks++; if (pulses != 4) begin errors++; $display("[TB] FAIL full_updates: got %0d expected 4", pulses); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("[TB] FAIL full_underrun: got %b expected 1", underrun); end
    checks++; if (thermo_out !== 4'b1111) begin errors++; $display("[TB] FAIL full_hold: got %b expected 1111", thermo_out); end
    enable = 1'b0;
  endtask

  task test_underrun;
    do_reset;
    enable = 1'b1;
    for (int c = 0; c < 4; c++) step;
    checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL under_early: got %b expected 0", underrun); end
    step;
    checks++; if (underrun !== 1'b1) begin errors++; $display("[TB] FAIL under_set: got %b expected 1", underrun); end
    checks++; if (thermo_out !== 4'b0000 || update_pulse !== 1'b0) begin errors++; $display("[TB] FAIL under_hold: got %b/%b expected 0000/0", thermo_out, update_pulse); end
    clear_flags = 1'b1;
    step;
    clear_flags = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL under_clear: got %b expected 0", underrun); end
    enable = 1'b0;
  endtask

  task test_saturation;
    int n; bit seen;
    do_reset;
    push(3'd6); push(3'd1);
    enable = 1'b1;
    wait_pulse(1'b0, 12, n, seen);
    checks++; if (!seen || thermo_out !== 4'b1111) begin errors++; $display("[TB] FAIL sat_thermo: got %b (seen=%b) expected 1111", thermo_out, seen); end
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("[TB] FAIL sat_flag: got %b expected 1", sat_flag); end
    wait_pulse(1'b0, 12, n, seen);
    checks++; if (!seen || thermo_out !== 4'b0001) begin errors++; $display("[TB] FAIL sat_ptr: got %b (seen=%b) expected 0001", thermo_out, seen); end
    enable = 1'b0;
  endtask

  task test_fixed_abort;
    int n; bit seen;
    do_reset;
    push(3'd3); push(3'd3); push(3'd3);
    enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_pulse(1'b1, 12, n, seen);
      checks++; if (!seen || f_thermo_out !== 4'b0111) begin errors++; $display("[TB] FAIL fix_thermo%0d: got %b (seen=%b) expected 0111", i, f_thermo_out, seen); end
    end
    step;
    enable = 1'b0;
    step;
    checks++; if (f_thermo_out !== 4'b0000) begin errors++; $display("[TB] FAIL abort_thermo: got %b expected 0000", f_thermo_out); end
    checks++; if (f_fifo_level !== 3'd1) begin errors++; $display("[TB] FAIL abort_level: got %0d expected 1", f_fifo_level); end
    enable = 1'b1;
    wait_pulse(1'b1, 12, n, seen);
    checks++; if (!seen || n != 5) begin errors++; $display("[TB] FAIL abort_restart: got %0d cycles (seen=%b) expected 5", n, seen); end
    checks++; if (f_thermo_out !== 4'b0111 || f_fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL abort_retained: got %b/%0d expected 0111/0", f_thermo_out, f_fifo_level); end
    enable = 1'b0;
  endtask

  initial begin
    test_reset;
    test_dwa;
    test_full;
    test_underrun;
    test_saturation;
    test_fixed_abort;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
